// File: rtl/ddr_responder_if.sv
// DDR request/response bundle between the channel arbiter and the memory.
// master = arbiter side, slave = memory responder side.
interface ddr_responder_if;
    logic         ddr_chip_enable;
    logic [18:0]  ddr_index;
    logic         ddr_write_enable;
    logic         ddr_burst_mode;
    logic [63:0]  ddr_opstore_write_mask;
    logic [63:0]  ddr_opstore_write_data;
    logic [63:0]  ddr_opload_read_data;
    logic [511:0] ddr_pc_read_inst;
    logic         ddr_operation_done;
    logic         ddr_ready;

    modport master (
        output ddr_chip_enable,
        output ddr_index,
        output ddr_write_enable,
        output ddr_burst_mode,
        output ddr_opstore_write_mask,
        output ddr_opstore_write_data,
        input  ddr_opload_read_data,
        input  ddr_pc_read_inst,
        input  ddr_operation_done,
        input  ddr_ready
    );

    modport slave (
        input  ddr_chip_enable,
        input  ddr_index,
        input  ddr_write_enable,
        input  ddr_burst_mode,
        input  ddr_opstore_write_mask,
        input  ddr_opstore_write_data,
        output ddr_opload_read_data,
        output ddr_pc_read_inst,
        output ddr_operation_done,
        output ddr_ready
    );
endinterface

// File: rtl/ddr_responder.sv
// Behavioural DDR responder: masked single writes, single reads and
// 8-word burst reads after a fixed access latency.
// Ports: clock, reset (async, active-high); ddr (slave side of ddr_responder_if).
module ddr_responder #(
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int LATENCY        = 4
) (
    input  logic           clock,
    input  logic           reset,
    ddr_responder_if.slave ddr
);
    localparam int AW    = MEM_DEPTH_LOG2;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        BURST,
        DONE
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]     beat_q;
    logic [AW-1:0]  addr_q;
    logic           we_q;
    logic           burst_q;
    logic [63:0]    mask_q;
    logic [63:0]    data_q;
    logic [63:0]    rd_data_q;
    logic [511:0]   inst_q;
    logic           commit;

    logic [63:0]    mem [0:(1 << AW) - 1];

    // index bits above the array depth alias onto the same words
    logic unused_idx_hi;
    assign unused_idx_hi = ^ddr.ddr_index[18:AW];

    assign ddr.ddr_ready            = (state_q == IDLE);
    assign ddr.ddr_operation_done   = (state_q == DONE);
    assign ddr.ddr_opload_read_data = rd_data_q;
    assign ddr.ddr_pc_read_inst     = inst_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ddr.ddr_chip_enable) state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = burst_q ? BURST : DONE;
            end
            BURST: begin
                if (beat_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            beat_q    <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            burst_q   <= 1'b0;
            mask_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
            inst_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ddr.ddr_chip_enable) begin
                        addr_q  <= ddr.ddr_index[AW-1:0];
                        we_q    <= ddr.ddr_write_enable;
                        burst_q <= ddr.ddr_burst_mode;
                        mask_q  <= ddr.ddr_opstore_write_mask;
                        data_q  <= ddr.ddr_opstore_write_data;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        if (burst_q) begin
                            beat_q <= 3'd0;
                        end else if (!we_q) begin
                            rd_data_q <= mem[addr_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                BURST: begin
                    // line base is the 8-aligned word; beat selects lane
                    inst_q[{beat_q, 6'd0} +: 64] <= mem[{addr_q[AW-1:3], beat_q}];
                    beat_q <= beat_q + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // storage has no reset; a write only commits on its final ACCESS edge
    assign commit = (state_q == ACCESS) && (cnt_q == '0) && we_q && !burst_q;

    always_ff @(posedge clock) begin
        if (commit) begin
            mem[addr_q] <= (mem[addr_q] & ~mask_q) | (data_q & mask_q);
        end
    end
endmodule

// File: tb/tb_ddr_responder.sv
// Directed self-checking bench for ddr_responder with a memory model
// and scoreboard queues for read and burst results.
module tb_ddr_responder;
    localparam int LAT = 4;
    localparam int MDL = 12;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   kind;

    logic [63:0]  mdl [int];
    logic [63:0]  rd_q [$];
    logic [511:0] line_q [$];

    ddr_responder_if dif ();

    ddr_responder #(
        .MEM_DEPTH_LOG2(MDL),
        .LATENCY(LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ddr(dif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int key(input logic [18:0] idx);
        return int'(idx) & ((1 << MDL) - 1);
    endfunction

    task automatic issue(input bit we, input bit burst,
                         input logic [18:0] idx,
                         input logic [63:0] mask,
                         input logic [63:0] data);
        logic [511:0] line;
        int b;
        chk("ready_before_issue", dif.ddr_ready, 1'b1);
        if (burst) begin
            b = key(idx) & ~7;
            for (int k = 0; k < 8; k++) line[k*64 +: 64] = mdl[b + k];
            line_q.push_back(line);
            kind = 2;
        end else if (we) begin
            if (!mdl.exists(key(idx))) mdl[key(idx)] = '0;
            mdl[key(idx)] = (mdl[key(idx)] & ~mask) | (data & mask);
            kind = 0;
        end else begin
            rd_q.push_back(mdl[key(idx)]);
            kind = 1;
        end
        dif.ddr_chip_enable        = 1'b1;
        dif.ddr_write_enable       = we;
        dif.ddr_burst_mode         = burst;
        dif.ddr_index              = idx;
        dif.ddr_opstore_write_mask = mask;
        dif.ddr_opstore_write_data = data;
        @(posedge clock);
        #1;
        dif.ddr_chip_enable = 1'b0;
    endtask

    // n0 = edges already elapsed since acceptance
    task automatic wait_done(input string tag, input int exp_lat, input int n0);
        int n;
        bit seen;
        bit rdy_low;
        n = n0;
        seen = 0;
        rdy_low = 1;
        while (!seen && n < 64) begin
            @(posedge clock);
            #1;
            n++;
            if (dif.ddr_ready !== 1'b0) rdy_low = 0;
            if (dif.ddr_operation_done === 1'b1) seen = 1;
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_ready_low"}, rdy_low, 1'b1);
        if (seen && kind == 1 && rd_q.size() > 0)
            chk({tag, "_rdata"}, dif.ddr_opload_read_data, rd_q.pop_front());
        if (seen && kind == 2 && line_q.size() > 0)
            chk({tag, "_line"}, dif.ddr_pc_read_inst, line_q.pop_front());
        @(posedge clock);
        #1;
        chk({tag, "_ready_after"}, dif.ddr_ready, 1'b1);
        chk({tag, "_done_1cyc"}, dif.ddr_operation_done, 1'b0);
    endtask

    initial begin
        int extra;
        logic [63:0] held;
        checks = 0;
        errors = 0;
        kind = 0;
        reset = 1'b1;
        dif.ddr_chip_enable        = 1'b1;
        dif.ddr_index              = 19'h10;
        dif.ddr_write_enable       = 1'b1;
        dif.ddr_burst_mode         = 1'b0;
        dif.ddr_opstore_write_mask = '1;
        dif.ddr_opstore_write_data = 64'h1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", dif.ddr_ready, 1'b1);
        chk("rst_done", dif.ddr_operation_done, 1'b0);
        chk("rst_rdata", dif.ddr_opload_read_data, 64'h0);
        chk("rst_inst", dif.ddr_pc_read_inst, 512'h0);
        dif.ddr_chip_enable = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // basic write then read
        issue(1, 0, 19'h10, '1, 64'hDEADBEEF_CAFEF00D);
        wait_done("t1_wr", LAT, 0);
        issue(0, 0, 19'h10, '0, '0);
        wait_done("t1_rd", LAT, 0);
        chk("t1_const", dif.ddr_opload_read_data, 64'hDEADBEEF_CAFEF00D);

        // masked write
        issue(1, 0, 19'h20, '1, 64'hFFFFFFFF_FFFFFFFF);
        wait_done("t2_wr0", LAT, 0);
        issue(1, 0, 19'h20, 64'h00000000_FFFF0000, 64'h12345678_9ABCDEF0);
        wait_done("t2_wr1", LAT, 0);
        issue(0, 0, 19'h20, '0, '0);
        wait_done("t2_rd", LAT, 0);
        chk("t2_const", dif.ddr_opload_read_data, 64'hFFFFFFFF_9ABCFFFF);

        // burst line fill from an unaligned index
        for (int k = 0; k < 8; k++) begin
            issue(1, 0, 19'h40 + 19'(k), '1, 64'h1000 + 64'(k));
            wait_done("t3_wr", LAT, 0);
        end
        held = dif.ddr_opload_read_data;
        issue(0, 1, 19'h45, '0, '0);
        wait_done("t3_burst", LAT + 8, 0);
        for (int k = 0; k < 8; k++)
            chk("t3_lane", dif.ddr_pc_read_inst[k*64 +: 64], 64'h1000 + 64'(k));
        chk("t3_rdata_held", dif.ddr_opload_read_data, held);

        // request during ACCESS is ignored
        issue(1, 0, 19'h30, '1, 64'h77);
        wait_done("t4_wr", LAT, 0);
        issue(0, 0, 19'h10, '0, '0);
        @(posedge clock);
        #1;
        dif.ddr_chip_enable  = 1'b1;
        dif.ddr_write_enable = 1'b1;
        dif.ddr_burst_mode   = 1'b0;
        dif.ddr_index        = 19'h30;
        dif.ddr_opstore_write_mask = '1;
        dif.ddr_opstore_write_data = 64'hAA;
        @(posedge clock);
        #1;
        dif.ddr_chip_enable = 1'b0;
        wait_done("t4_rd", LAT, 2);
        extra = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (dif.ddr_operation_done === 1'b1) extra++;
        end
        chk("t4_extra_done", extra, 0);
        issue(0, 0, 19'h30, '0, '0);
        wait_done("t4_rb", LAT, 0);
        chk("t4_const", dif.ddr_opload_read_data, 64'h77);

        // reset in the middle of a burst
        issue(0, 1, 19'h40, '0, '0);
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_ready", dif.ddr_ready, 1'b1);
        chk("t5_done", dif.ddr_operation_done, 1'b0);
        chk("t5_inst", dif.ddr_pc_read_inst, 512'h0);
        chk("t5_rdata", dif.ddr_opload_read_data, 64'h0);
        line_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        extra = 0;
        repeat (16) begin
            @(posedge clock);
            #1;
            if (dif.ddr_operation_done === 1'b1) extra++;
        end
        chk("t5_no_done", extra, 0);
        issue(0, 0, 19'h10, '0, '0);
        wait_done("t5_rd", LAT, 0);
        chk("t5_const", dif.ddr_opload_read_data, 64'hDEADBEEF_CAFEF00D);

        // index aliasing above the array depth
        issue(1, 0, 19'h01010, '1, 64'h55);
        wait_done("t6_wr", LAT, 0);
        issue(0, 0, 19'h00010, '0, '0);
        wait_done("t6_rd", LAT, 0);
        chk("t6_const", dif.ddr_opload_read_data, 64'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
